// File: rtl/battleship_game_ctrl.sv
// Battleship game sequencer: ship-count selection, placement, alternating turns, game over.
// Optional per-turn timeout timer enabled by defining BS_TURN_TIMER_EN.
module battleship_game_ctrl #(
  parameter int unsigned MAX_SHIPS   = 5,
  parameter int unsigned TICK_CYCLES = 50_000_000,
  parameter int unsigned TURN_TICKS  = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       btn_next,
  input  logic       btn_confirm,
  input  logic       place_ok,
  input  logic       player_shot_done,
  input  logic       player_hit,
  input  logic       pc_shot_done,
  input  logic       pc_hit,
  output logic [2:0] state,
  output logic [2:0] num_ships,
  output logic [2:0] ship_idx,
  output logic       en_select,
  output logic       en_place,
  output logic       en_player_shot,
  output logic       en_pc_shot,
  output logic [4:0] player_cells_left,
  output logic [4:0] pc_cells_left,
  output logic [3:0] timer_ticks,
  output logic       timeout,
  output logic       player_won
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SELECT  = 3'd1;
  localparam logic [2:0] S_PLACE   = 3'd2;
  localparam logic [2:0] S_P_TURN  = 3'd3;
  localparam logic [2:0] S_PC_TURN = 3'd4;
  localparam logic [2:0] S_OVER    = 3'd5;
  localparam logic [2:0] MAX_N     = 3'(MAX_SHIPS);

  logic [2:0] r_state, r_num_ships, r_ship_idx;
  logic [4:0] r_player_cells, r_pc_cells;
  logic       r_en_select, r_en_place, r_en_player_shot, r_en_pc_shot, r_player_won;

  logic [2:0] w_state, w_num_ships, w_ship_idx;
  logic [4:0] w_player_cells, w_pc_cells, w_total;
  logic       w_player_won;
  logic       w_expire;

`ifdef BS_TURN_TIMER_EN
  localparam int unsigned PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  logic [PW-1:0] r_presc;
  logic [3:0]    r_ticks;
  logic          r_timeout;

  assign w_expire = (r_state == S_P_TURN) && (r_ticks == 4'(TURN_TICKS));

  // Cleared on every cycle not spent continuously in P_TURN, so entry always starts from zero.
  always_ff @(posedge clk) begin
    if (rst || (r_state != S_P_TURN) || (w_state != S_P_TURN)) begin
      r_presc <= '0;
      r_ticks <= '0;
    end else if (r_presc == PW'(TICK_CYCLES - 1)) begin
      r_presc <= '0;
      r_ticks <= r_ticks + 4'd1;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_timeout <= 1'b0;
    else     r_timeout <= w_expire && !player_shot_done;
  end

  assign timer_ticks = r_ticks;
  assign timeout     = r_timeout;
`else
  assign w_expire    = 1'b0;
  assign timer_ticks = '0;
  assign timeout     = 1'b0;

  // Timer parameters stay on the interface so both builds share one instantiation.
  if ((TICK_CYCLES == 0) || (TURN_TICKS == 0)) begin : g_timer_cfg_unused
  end
`endif

  always_comb begin
    w_state        = r_state;
    w_num_ships    = r_num_ships;
    w_ship_idx     = r_ship_idx;
    w_player_cells = r_player_cells;
    w_pc_cells     = r_pc_cells;
    w_player_won   = r_player_won;
    w_total        = 5'(({3'b000, r_num_ships} * ({3'b000, r_num_ships} + 6'd1)) >> 1);
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state     = S_SELECT;
          w_num_ships = 3'd1;
        end
      end
      S_SELECT: begin
        if (btn_confirm) begin
          w_state        = S_PLACE;
          w_ship_idx     = 3'd1;
          w_player_cells = w_total;
          w_pc_cells     = w_total;
        end else if (btn_next) begin
          w_num_ships = (r_num_ships == MAX_N) ? 3'd1 : r_num_ships + 3'd1;
        end
      end
      S_PLACE: begin
        if (place_ok) begin
          if (r_ship_idx == r_num_ships) w_state    = S_P_TURN;
          else                           w_ship_idx = r_ship_idx + 3'd1;
        end
      end
      S_P_TURN: begin
        if (player_shot_done) begin
          w_state = S_PC_TURN;
          if (player_hit && (r_pc_cells != '0)) begin
            w_pc_cells = r_pc_cells - 5'd1;
            if (r_pc_cells == 5'd1) begin
              w_state      = S_OVER;
              w_player_won = 1'b1;
            end
          end
        end else if (w_expire) begin
          w_state = S_PC_TURN;
        end
      end
      S_PC_TURN: begin
        if (pc_shot_done) begin
          w_state = S_P_TURN;
          if (pc_hit && (r_player_cells != '0)) begin
            w_player_cells = r_player_cells - 5'd1;
            if (r_player_cells == 5'd1) begin
              w_state      = S_OVER;
              w_player_won = 1'b0;
            end
          end
        end
      end
      S_OVER: begin
        if (start) begin
          w_state        = S_SELECT;
          w_num_ships    = 3'd1;
          w_player_cells = '0;
          w_pc_cells     = '0;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= S_IDLE;
      r_num_ships      <= 3'd1;
      r_ship_idx       <= 3'd1;
      r_player_cells   <= '0;
      r_pc_cells       <= '0;
      r_player_won     <= 1'b0;
      r_en_select      <= 1'b0;
      r_en_place       <= 1'b0;
      r_en_player_shot <= 1'b0;
      r_en_pc_shot     <= 1'b0;
    end else begin
      r_state          <= w_state;
      r_num_ships      <= w_num_ships;
      r_ship_idx       <= w_ship_idx;
      r_player_cells   <= w_player_cells;
      r_pc_cells       <= w_pc_cells;
      r_player_won     <= w_player_won;
      r_en_select      <= (w_state == S_SELECT);
      r_en_place       <= (w_state == S_PLACE);
      r_en_player_shot <= (w_state == S_P_TURN);
      r_en_pc_shot     <= (w_state == S_PC_TURN);
    end
  end

  assign state             = r_state;
  assign num_ships         = r_num_ships;
  assign ship_idx          = r_ship_idx;
  assign en_select         = r_en_select;
  assign en_place          = r_en_place;
  assign en_player_shot    = r_en_player_shot;
  assign en_pc_shot        = r_en_pc_shot;
  assign player_cells_left = r_player_cells;
  assign pc_cells_left     = r_pc_cells;
  assign player_won        = r_player_won;

endmodule

// File: tb/tb_battleship_game_ctrl.sv
// Scoreboard bench for battleship_game_ctrl with TICK_CYCLES=4, TURN_TICKS=3, MAX_SHIPS=5.
module tb_battleship_game_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, btn_next, btn_confirm, place_ok;
  logic       player_shot_done, player_hit, pc_shot_done, pc_hit;
  logic [2:0] state, num_ships, ship_idx;
  logic       en_select, en_place, en_player_shot, en_pc_shot;
  logic [4:0] player_cells_left, pc_cells_left;
  logic [3:0] timer_ticks;
  logic       timeout, player_won;

  localparam logic [8:0] I_NONE  = 9'h000;
  localparam logic [8:0] I_START = 9'h001;
  localparam logic [8:0] I_NEXT  = 9'h002;
  localparam logic [8:0] I_CONF  = 9'h004;
  localparam logic [8:0] I_POK   = 9'h008;
  localparam logic [8:0] I_PSD   = 9'h010;
  localparam logic [8:0] I_PH    = 9'h020;
  localparam logic [8:0] I_PCSD  = 9'h040;
  localparam logic [8:0] I_PCH   = 9'h080;
  localparam logic [8:0] I_RST   = 9'h100;

  typedef struct {
    string tag;
    int    st, ns, idx, plc, pcc, tt, to, won, wdc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  battleship_game_ctrl #(.MAX_SHIPS(5), .TICK_CYCLES(4), .TURN_TICKS(3)) dut (
    .clk(clk), .rst(rst), .start(start), .btn_next(btn_next), .btn_confirm(btn_confirm),
    .place_ok(place_ok), .player_shot_done(player_shot_done), .player_hit(player_hit),
    .pc_shot_done(pc_shot_done), .pc_hit(pc_hit), .state(state), .num_ships(num_ships),
    .ship_idx(ship_idx), .en_select(en_select), .en_place(en_place),
    .en_player_shot(en_player_shot), .en_pc_shot(en_pc_shot),
    .player_cells_left(player_cells_left), .pc_cells_left(pc_cells_left),
    .timer_ticks(timer_ticks), .timeout(timeout), .player_won(player_won)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({e.tag, "/state"}, {29'b0, state}, e.st);
    chk({e.tag, "/num_ships"}, {29'b0, num_ships}, e.ns);
    chk({e.tag, "/ship_idx"}, {29'b0, ship_idx}, e.idx);
    chk({e.tag, "/en_select"}, {31'b0, en_select}, (e.st == 1) ? 1 : 0);
    chk({e.tag, "/en_place"}, {31'b0, en_place}, (e.st == 2) ? 1 : 0);
    chk({e.tag, "/en_player_shot"}, {31'b0, en_player_shot}, (e.st == 3) ? 1 : 0);
    chk({e.tag, "/en_pc_shot"}, {31'b0, en_pc_shot}, (e.st == 4) ? 1 : 0);
    chk({e.tag, "/player_cells"}, {27'b0, player_cells_left}, e.plc);
    chk({e.tag, "/pc_cells"}, {27'b0, pc_cells_left}, e.pcc);
    chk({e.tag, "/timer_ticks"}, {28'b0, timer_ticks}, e.tt);
    chk({e.tag, "/timeout"}, {31'b0, timeout}, e.to);
    if (e.wdc == 0) chk({e.tag, "/player_won"}, {31'b0, player_won}, e.won);
  endtask

  // Push the expected post-edge outputs, apply one cycle of stimulus, then compare.
  task automatic t(input logic [8:0] iv, input string tag, input int st, input int ns,
                   input int idx, input int plc, input int pcc, input int tt, input int to,
                   input int won, input int wdc);
    exp_t e;
    e.tag = tag; e.st = st; e.ns = ns; e.idx = idx; e.plc = plc; e.pcc = pcc;
    e.tt = tt; e.to = to; e.won = won; e.wdc = wdc;
    sb.push_back(e);
    @(negedge clk);
    {rst, pc_hit, pc_shot_done, player_hit, player_shot_done,
     place_ok, btn_confirm, btn_next, start} = iv;
    @(posedge clk);
    #1;
    {rst, pc_hit, pc_shot_done, player_hit, player_shot_done,
     place_ok, btn_confirm, btn_next, start} = '0;
    pop_check();
  endtask

  initial begin
    {rst, pc_hit, pc_shot_done, player_hit, player_shot_done,
     place_ok, btn_confirm, btn_next, start} = '0;

    // 1: select three ships
    t(I_RST,   "t1_reset",   0, 1, 1, 0, 0, 0, 0, 0, 0);
    t(I_START, "t1_start",   1, 1, 1, 0, 0, 0, 0, 0, 0);
    t(I_NEXT,  "t1_next1",   1, 2, 1, 0, 0, 0, 0, 0, 0);
    t(I_NEXT,  "t1_next2",   1, 3, 1, 0, 0, 0, 0, 0, 0);
    t(I_CONF,  "t1_confirm", 2, 3, 1, 6, 6, 0, 0, 0, 0);

    // 2: wrap past MAX_SHIPS, then next+confirm together
    t(I_RST,   "t2_reset", 0, 1, 1, 0, 0, 0, 0, 0, 0);
    t(I_START, "t2_start", 1, 1, 1, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 5; k++)
      t(I_NEXT, "t2_next", 1, (k % 5) + 1, 1, 0, 0, 0, 0, 0, 0);
    t(I_NEXT | I_CONF, "t2_next_conf", 2, 1, 1, 1, 1, 0, 0, 0, 0);

    // 3: placement of two ships, then a few turns
    t(I_RST,   "t3_reset",   0, 1, 1, 0, 0, 0, 0, 0, 0);
    t(I_START, "t3_start",   1, 1, 1, 0, 0, 0, 0, 0, 0);
    t(I_NEXT,  "t3_next",    1, 2, 1, 0, 0, 0, 0, 0, 0);
    t(I_CONF,  "t3_confirm", 2, 2, 1, 3, 3, 0, 0, 0, 0);
    t(I_POK,   "t3_place1",  2, 2, 2, 3, 3, 0, 0, 0, 0);
    t(I_POK,   "t3_place2",  3, 2, 2, 3, 3, 0, 0, 0, 0);
    t(I_PCSD | I_PCH, "t3_pc_ignored", 3, 2, 2, 3, 3, 0, 0, 0, 0);
    t(I_PSD | I_PH,   "t3_p_hit",      4, 2, 2, 3, 2, 0, 0, 0, 0);
    t(I_PSD | I_PH,   "t3_p_ignored",  4, 2, 2, 3, 2, 0, 0, 0, 0);
    t(I_PCSD,         "t3_pc_miss",    3, 2, 2, 3, 2, 0, 0, 0, 0);
    t(I_PSD,          "t3_p_miss",     4, 2, 2, 3, 2, 0, 0, 0, 0);
    t(I_PCSD | I_PCH, "t3_pc_hit",     3, 2, 2, 2, 2, 0, 0, 0, 0);

    // 4: player sinks the only PC cell; OVER holds; restart; PC wins
    t(I_RST,   "t4_reset",   0, 1, 1, 0, 0, 0, 0, 0, 0);
    t(I_START, "t4_start",   1, 1, 1, 0, 0, 0, 0, 0, 0);
    t(I_CONF,  "t4_confirm", 2, 1, 1, 1, 1, 0, 0, 0, 0);
    t(I_POK,   "t4_place",   3, 1, 1, 1, 1, 0, 0, 0, 0);
    t(I_PSD | I_PH,   "t4_p_win",      5, 1, 1, 1, 0, 0, 0, 1, 0);
    t(I_PCSD | I_PCH, "t4_over_hold",  5, 1, 1, 1, 0, 0, 0, 1, 0);
    t(I_NONE,         "t4_over_idle",  5, 1, 1, 1, 0, 0, 0, 1, 0);
    t(I_START,        "t4_restart",    1, 1, 1, 0, 0, 0, 0, 0, 1);
    t(I_CONF,         "t4_confirm2",   2, 1, 1, 1, 1, 0, 0, 0, 1);
    t(I_POK,          "t4_place2",     3, 1, 1, 1, 1, 0, 0, 0, 1);
    t(I_PSD,          "t4_p_miss",     4, 1, 1, 1, 1, 0, 0, 0, 1);
    t(I_PCSD | I_PCH, "t4_pc_win",     5, 1, 1, 0, 1, 0, 0, 0, 0);

    // 5: turn timer
    t(I_RST,   "t5_reset",   0, 1, 1, 0, 0, 0, 0, 0, 0);
    t(I_START, "t5_start",   1, 1, 1, 0, 0, 0, 0, 0, 0);
    t(I_NEXT,  "t5_next",    1, 2, 1, 0, 0, 0, 0, 0, 0);
    t(I_CONF,  "t5_confirm", 2, 2, 1, 3, 3, 0, 0, 0, 0);
    t(I_POK,   "t5_place1",  2, 2, 2, 3, 3, 0, 0, 0, 0);
    t(I_POK,   "t5_place2",  3, 2, 2, 3, 3, 0, 0, 0, 0);
`ifdef BS_TURN_TIMER_EN
    for (int k = 1; k <= 12; k++)
      t(I_NONE, "t5_idle", 3, 2, 2, 3, 3, k / 4, 0, 0, 0);
    t(I_NONE, "t5_timeout",    4, 2, 2, 3, 3, 0, 1, 0, 0);
    t(I_NONE, "t5_pulse_end",  4, 2, 2, 3, 3, 0, 0, 0, 0);
    t(I_PCSD, "t5_back",       3, 2, 2, 3, 3, 0, 0, 0, 0);
    for (int k = 1; k <= 12; k++)
      t(I_NONE, "t5_idle2", 3, 2, 2, 3, 3, k / 4, 0, 0, 0);
    t(I_PSD | I_PH, "t5_shot_wins", 4, 2, 2, 3, 2, 0, 0, 0, 0);
    t(I_NONE,       "t5_no_pulse",  4, 2, 2, 3, 2, 0, 0, 0, 0);
`else
    for (int k = 1; k <= 20; k++)
      t(I_NONE, "t5_no_timer", 3, 2, 2, 3, 3, 0, 0, 0, 0);
    t(I_PSD | I_PH, "t5_shot", 4, 2, 2, 3, 2, 0, 0, 0, 0);
`endif

    // 6: reset from PC_TURN with four player cells left
    t(I_RST,   "t6_reset",   0, 1, 1, 0, 0, 0, 0, 0, 0);
    t(I_START, "t6_start",   1, 1, 1, 0, 0, 0, 0, 0, 0);
    t(I_NEXT,  "t6_next1",   1, 2, 1, 0, 0, 0, 0, 0, 0);
    t(I_NEXT,  "t6_next2",   1, 3, 1, 0, 0, 0, 0, 0, 0);
    t(I_CONF,  "t6_confirm", 2, 3, 1, 6, 6, 0, 0, 0, 0);
    t(I_POK,   "t6_place1",  2, 3, 2, 6, 6, 0, 0, 0, 0);
    t(I_POK,   "t6_place2",  2, 3, 3, 6, 6, 0, 0, 0, 0);
    t(I_POK,   "t6_place3",  3, 3, 3, 6, 6, 0, 0, 0, 0);
    t(I_PSD,          "t6_p1",  4, 3, 3, 6, 6, 0, 0, 0, 0);
    t(I_PCSD | I_PCH, "t6_pc1", 3, 3, 3, 5, 6, 0, 0, 0, 0);
    t(I_PSD,          "t6_p2",  4, 3, 3, 5, 6, 0, 0, 0, 0);
    t(I_PCSD | I_PCH, "t6_pc2", 3, 3, 3, 4, 6, 0, 0, 0, 0);
    t(I_PSD,          "t6_p3",  4, 3, 3, 4, 6, 0, 0, 0, 0);
    t(I_RST | I_PCSD | I_PCH, "t6_rst", 0, 1, 1, 0, 0, 0, 0, 0, 0);

    chk("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/battleship_game_ctrl.md
Name: battleship_game_ctrl

Overview:
Top-level game sequencer for the battleship board. It owns the phases: ship-count selection, player ship placement, alternating player/PC shot turns, and game over. It drives the enable lines of the selection, placement and shot datapaths. It also tracks remaining ship cells per side and runs the per-turn timeout.

Parameters:
MAX_SHIPS, 5, maximum selectable ships (1..7); ship k has size k, so a side holds n(n+1)/2 cells
TICK_CYCLES, 50_000_000, clk cycles per timer tick (1 s at 50 MHz)
TURN_TICKS, 15, ticks allowed per player turn before timeout

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse: leave IDLE
btn_next  in  1  one-cycle pulse: increment selected ship count
btn_confirm  in  1  one-cycle pulse: accept selected count
place_ok  in  1  pulse from placement datapath: current ship legally placed
player_shot_done  in  1  pulse: player shot resolved
player_hit  in  1  qualifies player_shot_done: shot hit a PC ship cell
pc_shot_done  in  1  pulse: PC shot resolved
pc_hit  in  1  qualifies pc_shot_done: shot hit a player ship cell
state  out  3  IDLE=0, SELECT=1, PLACE=2, P_TURN=3, PC_TURN=4, OVER=5
num_ships  out  3  selected ship count
ship_idx  out  3  size/index of ship being placed (1..num_ships)
en_select  out  1  high in SELECT
en_place  out  1  high in PLACE
en_player_shot  out  1  high in P_TURN
en_pc_shot  out  1  high in PC_TURN
player_cells_left  out  5  unsunk player ship cells
pc_cells_left  out  5  unsunk PC ship cells
timer_ticks  out  4  ticks elapsed in current P_TURN
timeout  out  1  one-cycle pulse on player turn timeout
player_won  out  1  valid in OVER: 1 player won, 0 PC won

Behaviour:
- Reset values: state=IDLE, num_ships=1, ship_idx=1, all enables=0, both cells_left=0, timer_ticks=0, timeout=0, player_won=0. A reset in any state returns to IDLE on the next edge and discards all in-progress counts.
- All outputs are registered. Enables and state change on the same edge. Each input pulse acts on the edge where it is sampled.
- IDLE: start -> SELECT with num_ships=1.
- SELECT: btn_next increments num_ships; MAX_SHIPS wraps to 1. btn_confirm -> PLACE, ship_idx=1, both cells_left = num_ships*(num_ships+1)/2 (MAX_SHIPS=5 gives 15). If btn_next and btn_confirm arrive together, confirm wins and the count is unchanged.
- PLACE: place_ok increments ship_idx. place_ok when ship_idx==num_ships -> P_TURN, ship_idx held.
- P_TURN: player_shot_done -> PC_TURN. If player_hit is also set, pc_cells_left decrements. A decrement to 0 goes to OVER with player_won=1 instead.
- PC_TURN: pc_shot_done -> P_TURN. If pc_hit is also set, player_cells_left decrements. A decrement to 0 goes to OVER with player_won=0.
- Decrements saturate at 0. Shot pulses outside their own state are ignored.
- OVER: holds all outputs. start -> SELECT with num_ships=1 and cells_left cleared.
- Timer (P_TURN only):
  - Prescaler counts 0..TICK_CYCLES-1; each wrap increments timer_ticks.
  - Prescaler and timer_ticks clear on every entry to P_TURN and are held at 0 elsewhere.
  - When timer_ticks reaches TURN_TICKS, timeout pulses for one cycle and state -> PC_TURN with no cell change.
  - If player_shot_done coincides with timeout, the shot is processed and timeout is suppressed.

Optional Feature:
Macro BS_TURN_TIMER_EN.
- Defined: timer and timeout behave as above.
- Undefined: no prescaler or timer logic. timer_ticks is tied to 0, timeout to 0, and P_TURN waits indefinitely for player_shot_done.

Test Plan:
Bench settings: TICK_CYCLES=4, TURN_TICKS=3, MAX_SHIPS=5.
1. rst, start, btn_next x2, btn_confirm -> state=PLACE, num_ships=3, ship_idx=1, both cells_left=6.
2. In SELECT, btn_next x5 from 1 -> num_ships=1 (wrap). Next cycle, btn_next+btn_confirm same cycle -> PLACE, num_ships=1, cells_left=1.
3. num_ships=2, place_ok x2 -> ship_idx 1->2, then state=P_TURN, en_player_shot=1, en_place=0.
4. num_ships=1, P_TURN: player_shot_done+player_hit -> OVER, player_won=1, pc_cells_left=0. A later pc_shot_done is ignored.
5. Timer enabled, P_TURN idle 12 cycles -> timer_ticks=3, timeout pulse, PC_TURN, cell counts unchanged. Repeat with player_shot_done on the timeout cycle -> no timeout, PC_TURN.
6. rst asserted in PC_TURN with player_cells_left=4 -> next cycle IDLE, all outputs at reset values.
